// File: rtl/beat_packer_if.sv
// Handshake bundle for beat_packer: narrow beat stream in, packed word stream out.
interface beat_packer_if #(
  parameter int DW    = 8,
  parameter int RATIO = 4
);
  logic [DW-1:0]       DataIn;
  logic                DataInVld;
  logic                DataInLast;
  logic                DataInRdy;
  logic [DW*RATIO-1:0] DataOut;
  logic [RATIO-1:0]    DataOutKeep;
  logic                DataOutLast;
  logic                DataOutVld;
  logic                DataOutRdy;

  modport master (
    output DataIn, DataInVld, DataInLast, DataOutRdy,
    input  DataInRdy, DataOut, DataOutKeep, DataOutLast, DataOutVld
  );

  modport slave (
    input  DataIn, DataInVld, DataInLast, DataOutRdy,
    output DataInRdy, DataOut, DataOutKeep, DataOutLast, DataOutVld
  );
endinterface

// File: rtl/beat_packer.sv
// Packs RATIO narrow beats (lane 0 first) into one wide word with per-lane keep;
// a Last beat closes the word early. One-deep output register, full throughput.
module beat_packer #(
  parameter int DW    = 8,
  parameter int RATIO = 4
) (
  input  logic         Clk,
  input  logic         Rstn,
  input  logic         Clear,
  beat_packer_if.slave bus
);
  localparam int             CW        = $clog2(RATIO);
  localparam logic [CW-1:0]  LAST_LANE = CW'(RATIO - 1);

  logic [DW*RATIO-1:0] acc_data, merged_data, out_data;
  logic [RATIO-1:0]    acc_keep, merged_keep, out_keep;
  logic [CW-1:0]       lane_cnt;
  logic                out_last, out_vld;
  logic                in_rdy, accept, closing, transmit;

  // Ready looks straight through to DataOutRdy so a draining word never costs a bubble.
  assign in_rdy   = (!out_vld || bus.DataOutRdy) && !Clear;
  assign accept   = bus.DataInVld && in_rdy;
  assign transmit = out_vld && bus.DataOutRdy;
  assign closing  = (lane_cnt == LAST_LANE) || bus.DataInLast;

  always_comb begin
    merged_data                      = acc_data;
    merged_data[lane_cnt*DW +: DW]   = bus.DataIn;
    merged_keep                      = acc_keep;
    merged_keep[lane_cnt]            = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      acc_data <= '0;
      acc_keep <= '0;
      lane_cnt <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
      out_vld  <= 1'b0;
    end else if (Clear) begin
      acc_data <= '0;
      acc_keep <= '0;
      lane_cnt <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      if (accept) begin
        if (closing) begin
          out_data <= merged_data;
          out_keep <= merged_keep;
          out_last <= bus.DataInLast;
          acc_data <= '0;
          acc_keep <= '0;
          lane_cnt <= '0;
        end else begin
          acc_data <= merged_data;
          acc_keep <= merged_keep;
          lane_cnt <= lane_cnt + CW'(1);
        end
      end
      // A closing accept wins over a transmit so back-to-back words keep Vld high.
      if (accept && closing) begin
        out_vld <= 1'b1;
      end else if (transmit) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.DataInRdy   = in_rdy;
  assign bus.DataOut     = out_data;
  assign bus.DataOutKeep = out_keep;
  assign bus.DataOutLast = out_last;
  assign bus.DataOutVld  = out_vld;
endmodule

// File: tb/tb_beat_packer.sv
// Scoreboard bench for beat_packer (DW=8, RATIO=4): driver feeds a packet-level model,
// an independent monitor pops expected words on every transmit.
module tb_beat_packer;
  localparam int DW    = 8;
  localparam int RATIO = 4;

  logic Clk   = 1'b0;
  logic Rstn  = 1'b0;
  logic Clear = 1'b0;

  beat_packer_if #(.DW(DW), .RATIO(RATIO)) bus ();
  beat_packer #(.DW(DW), .RATIO(RATIO)) dut (.Clk(Clk), .Rstn(Rstn), .Clear(Clear), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t        exp_q[$];
  byte unsigned part[$];
  bit           pushed[int];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words_seen = 0;
  int rst_count = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: collect accepted beats, emit a word on RATIO beats or Last.
  function automatic void model_beat(input byte unsigned d, input logic lst);
    word_t w;
    part.push_back(d);
    if (part.size() == RATIO || lst) begin
      w.data = '0;
      w.keep = '0;
      w.last = lst;
      foreach (part[i]) begin
        w.data[i*8 +: 8] = part[i];
        w.keep[i]        = 1'b1;
      end
      exp_q.push_back(w);
      pushed[cyc] = 1'b1;
      part.delete();
    end
  endfunction

  task automatic step(input logic vld, input logic [7:0] d, input logic lst,
                      input logic ordy, input logic clr, output logic acc);
    @(posedge Clk);
    #1;
    bus.DataInVld  = vld;
    bus.DataIn     = d;
    bus.DataInLast = lst;
    bus.DataOutRdy = ordy;
    Clear          = clr;
    @(negedge Clk);
    chk("in_rdy_rule", bus.DataInRdy, (!bus.DataOutVld || ordy) && !clr);
    acc = vld && bus.DataInRdy;
    if (clr) begin
      part.delete();
      exp_q.delete();
    end
    if (acc) model_beat(d, lst);
  endtask

  task automatic send(input logic [7:0] d, input logic lst, input logic ordy, input logic must_first);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, d, lst, ordy, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    chk("send_accept", acc, 1);
    if (must_first) chk("no_rdy_gap", n, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic chk_out(input string name, input logic [31:0] d, input logic [3:0] k, input logic l);
    chk({name, "_vld"},  bus.DataOutVld, 1);
    chk({name, "_data"}, bus.DataOut, d);
    chk({name, "_keep"}, bus.DataOutKeep, k);
    chk({name, "_last"}, bus.DataOutLast, l);
  endtask

  // Async reset pulse in the middle of a cycle; inputs idled before the next edge.
  task automatic pulse_reset();
    @(posedge Clk);
    #3 Rstn = 1'b0;
    #1;
    chk("rst_pulse_data", bus.DataOut, 0);
    chk("rst_pulse_keep", bus.DataOutKeep, 0);
    chk("rst_pulse_vld", bus.DataOutVld, 0);
    Rstn = 1'b1;
    bus.DataInVld = 1'b0;
    part.delete();
    exp_q.delete();
    pushed.delete();
    rst_count++;
  endtask

  word_t       mon_w;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;
  int          mon_rst_seen = 0;

  always @(negedge Clk) begin
    if (mon_rst_seen != rst_count) begin
      stall_prev   = 1'b0;
      mon_rst_seen = rst_count;
    end
    if (Rstn && !Clear) begin
      if (pushed.exists(cyc - 1)) chk("latency_vld", bus.DataOutVld, 1);
      if (stall_prev) begin
        chk("stall_vld", bus.DataOutVld, 1);
        chk("stall_data", bus.DataOut, prev_data);
        chk("stall_keep", bus.DataOutKeep, prev_keep);
        chk("stall_last", bus.DataOutLast, prev_last);
      end
      if (bus.DataOutVld && !bus.DataOutRdy) chk("stall_in_rdy", bus.DataInRdy, 0);
      if (bus.DataOutVld && bus.DataOutRdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus.DataOut, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_w = exp_q.pop_front();
          chk("word_data", bus.DataOut, mon_w.data);
          chk("word_keep", bus.DataOutKeep, mon_w.keep);
          chk("word_last", bus.DataOutLast, mon_w.last);
          words_seen++;
        end
      end
      stall_prev = bus.DataOutVld && !bus.DataOutRdy;
      prev_data  = bus.DataOut;
      prev_keep  = bus.DataOutKeep;
      prev_last  = bus.DataOutLast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    logic acc;
    bus.DataIn     = '0;
    bus.DataInVld  = 1'b0;
    bus.DataInLast = 1'b0;
    bus.DataOutRdy = 1'b0;

    repeat (3) @(negedge Clk);
    chk("rst_data", bus.DataOut, 0);
    chk("rst_keep", bus.DataOutKeep, 0);
    chk("rst_last", bus.DataOutLast, 0);
    chk("rst_vld", bus.DataOutVld, 0);
    @(posedge Clk);
    #1 Rstn = 1'b1;
    @(negedge Clk);
    chk("rst_in_rdy", bus.DataInRdy, 1);

    // Full word, then one-cycle Vld
    send(8'h11, 1'b0, 1'b1, 1'b1);
    send(8'h22, 1'b0, 1'b1, 1'b1);
    send(8'h33, 1'b0, 1'b1, 1'b1);
    send(8'h44, 1'b0, 1'b1, 1'b1);
    idle(1);
    chk_out("full_word", 32'h4433_2211, 4'b1111, 1'b0);
    idle(1);
    chk("full_word_vld_drop", bus.DataOutVld, 0);

    // Short packet closed by Last
    send(8'hAA, 1'b0, 1'b1, 1'b1);
    send(8'hBB, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk_out("short_pkt", 32'h0000_BBAA, 4'b0011, 1'b1);

    // Single-beat packet
    send(8'h5A, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk_out("single", 32'h0000_005A, 4'b0001, 1'b1);

    // Back-to-back words at full rate
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b1, 1'b1);
    idle(1);
    chk_out("b2b_second", 32'h0807_0605, 4'b1111, 1'b0);
    idle(2);

    // Output stall with upstream pushing
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, acc);
      chk("stall_no_accept", acc, 0);
    end
    chk_out("stall_hold", 32'h0403_0201, 4'b1111, 1'b0);
    for (int i = 5; i <= 8; i++) send(8'(i), (i == 8), 1'b1, 1'b0);
    idle(3);

    // Clear mid-packet
    send(8'hE1, 1'b0, 1'b1, 1'b1);
    send(8'hE2, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1, 1'b1);
    idle(1);
    chk_out("after_clear", 32'h0403_0201, 4'b1111, 1'b0);
    idle(2);

    // Async reset mid-packet
    send(8'hD1, 1'b0, 1'b1, 1'b1);
    send(8'hD2, 1'b0, 1'b1, 1'b1);
    pulse_reset();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1, 1'b1);
    idle(1);
    chk_out("after_reset", 32'h0403_0201, 4'b1111, 1'b0);
    idle(2);

    // Randomized traffic with backpressure and occasional clear
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 80) == 0), acc);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
    idle(4);
    chk("queue_empty", exp_q.size(), 0);
    chk("words_seen_nonzero", (words_seen > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
